// File: rtl/atm_multi_session_ctrl.sv
// Multi-account ATM session controller: card acceptance, PIN check with lockout,
// per-session withdrawal limit, idle timeout and a registered pulse interface.
module atm_multi_session_ctrl #(
  parameter int NUM_CARDS      = 8,
  parameter int CARD_WIDTH     = 3,
  parameter int PASSWORD_WIDTH = 4,
  parameter int BALANCE_WIDTH  = 20,
  parameter int PIN_BASE       = 5,
  parameter int INIT_BALANCE   = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int WD_LIMIT       = 500,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_insert,
  input  logic [CARD_WIDTH-1:0]     card_number,
  input  logic                      password_valid,
  input  logic [PASSWORD_WIDTH-1:0] password_input,
  input  logic                      language,
  input  logic                      op_valid,
  input  logic [1:0]                operation,
  input  logic [BALANCE_WIDTH-1:0]  value,
  input  logic                      another_valid,
  input  logic                      another_service,
  output logic                      card_present,
  output logic                      card_eject,
  output logic                      lang_sel,
  output logic [BALANCE_WIDTH-1:0]  updated_balance,
  output logic                      op_done,
  output logic                      error,
  output logic                      wrong_psw,
  output logic                      card_locked,
  output logic                      timeout
);

  localparam int BW = BALANCE_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [1:0] {IDLE, PIN, MENU, ANOTHER} state_t;

  function automatic logic [PASSWORD_WIDTH-1:0] pin_of(input int idx);
    return PASSWORD_WIDTH'(PIN_BASE + idx);
  endfunction

  state_t                  state, state_next;
  logic [TW-1:0]           timer;
  logic [AW-1:0]           attempts;
  logic [BW-1:0]           withdrawn;
  logic [CARD_WIDTH-1:0]   cur;
  logic [NUM_CARDS-1:0]    locked;
  logic [BW-1:0]           balance [NUM_CARDS];

  logic          card_ok, ins_locked, start_ok, pin_ok, last_try, accept, expire;
  logic [BW-1:0] bal_cur;
  logic [BW:0]   dep_sum, wd_sum;
  logic          dep_ok, wd_ok;

  logic          eject_n, error_n, op_done_n, wrong_n, lock_n, timeout_n;
  logic          upd_we, bal_we, wd_we, lock_set;
  logic [BW-1:0] upd_new;

  assign card_ok    = int'(card_number) < NUM_CARDS;
  assign ins_locked = card_ok && locked[card_number];
  assign start_ok   = card_insert && card_ok && !ins_locked;
  assign pin_ok     = password_input == pin_of(int'(cur));
  assign last_try   = (int'(attempts) + 1) >= MAX_ATTEMPTS;
  assign bal_cur    = balance[cur];
  // One extra bit exposes deposit overflow and keeps the limit sum exact.
  assign dep_sum    = {1'b0, bal_cur} + {1'b0, value};
  assign dep_ok     = !dep_sum[BW];
  assign wd_sum     = {1'b0, withdrawn} + {1'b0, value};
  assign wd_ok      = (value <= bal_cur) && (wd_sum <= (BW+1)'(WD_LIMIT));

  // Only the strobe belonging to the current state counts; others are dropped.
  assign accept = (state == IDLE    && card_insert)    ||
                  (state == PIN     && password_valid) ||
                  (state == MENU    && op_valid)       ||
                  (state == ANOTHER && another_valid);
  assign expire = (state != IDLE) && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = PIN;
      PIN:     if (password_valid) begin
                 if (pin_ok)        state_next = MENU;
                 else if (last_try) state_next = IDLE;
               end
      MENU:    if (op_valid) state_next = (operation == 2'b11) ? IDLE : ANOTHER;
      ANOTHER: if (another_valid) state_next = another_service ? MENU : IDLE;
      default: state_next = IDLE;
    endcase
    if (expire) state_next = IDLE;
  end

  always_comb begin
    eject_n   = 1'b0;
    error_n   = 1'b0;
    op_done_n = 1'b0;
    wrong_n   = 1'b0;
    lock_n    = 1'b0;
    timeout_n = 1'b0;
    upd_we    = 1'b0;
    bal_we    = 1'b0;
    wd_we     = 1'b0;
    lock_set  = 1'b0;
    upd_new   = bal_cur;
    unique case (state)
      IDLE: if (card_insert) begin
        if (!card_ok)        begin error_n = 1'b1; eject_n = 1'b1; end
        else if (ins_locked) begin lock_n  = 1'b1; eject_n = 1'b1; end
      end
      PIN: if (password_valid && !pin_ok) begin
        wrong_n = 1'b1;
        if (last_try) begin lock_n = 1'b1; eject_n = 1'b1; lock_set = 1'b1; end
      end
      MENU: if (op_valid) begin
        unique case (operation)
          2'b00: begin op_done_n = 1'b1; upd_we = 1'b1; end
          2'b01: if (dep_ok) begin
                   op_done_n = 1'b1; upd_we = 1'b1; bal_we = 1'b1;
                   upd_new   = dep_sum[BW-1:0];
                 end else error_n = 1'b1;
          2'b10: if (wd_ok) begin
                   op_done_n = 1'b1; upd_we = 1'b1; bal_we = 1'b1; wd_we = 1'b1;
                   upd_new   = bal_cur - value;
                 end else error_n = 1'b1;
          default: eject_n = 1'b1;
        endcase
      end
      ANOTHER: if (another_valid && !another_service) eject_n = 1'b1;
      default: ;
    endcase
    if (expire) begin timeout_n = 1'b1; eject_n = 1'b1; end
  end

  for (genvar g = 0; g < NUM_CARDS; g++) begin : g_acct
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        balance[g] <= BW'(INIT_BALANCE);
        locked[g]  <= 1'b0;
      end else if (cur == CARD_WIDTH'(g)) begin
        if (bal_we)   balance[g] <= upd_new;
        if (lock_set) locked[g]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer           <= '0;
      attempts        <= '0;
      withdrawn       <= '0;
      cur             <= '0;
      lang_sel        <= 1'b0;
      card_present    <= 1'b0;
      updated_balance <= '0;
      card_eject      <= 1'b0;
      error           <= 1'b0;
      op_done         <= 1'b0;
      wrong_psw       <= 1'b0;
      card_locked     <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      card_present <= (state_next != IDLE);
      card_eject   <= eject_n;
      error        <= error_n;
      op_done      <= op_done_n;
      wrong_psw    <= wrong_n;
      card_locked  <= lock_n;
      timeout      <= timeout_n;
      // An accepted strobe beats a simultaneous expiry because expire excludes accept.
      if (accept || state_next != state || state == IDLE) timer <= '0;
      else                                                 timer <= timer + TW'(1);
      if (state == IDLE && start_ok) begin
        cur       <= card_number;
        lang_sel  <= language;
        attempts  <= '0;
        withdrawn <= '0;
      end
      if (state == PIN && password_valid) attempts <= pin_ok ? '0 : attempts + AW'(1);
      if (upd_we) updated_balance <= upd_new;
      if (wd_we)  withdrawn <= wd_sum[BW-1:0];
    end
  end

endmodule

// File: tb/tb_atm_multi_session_ctrl.sv
// Scoreboard bench for atm_multi_session_ctrl: a session-level reference model predicts
// every output pulse and the cycle it must appear in; a monitor pops and compares.
module tb_atm_multi_session_ctrl;
  localparam int NC = 6, BW = 20, T = 1024, WDL = 500, MAXA = 3, INIT = 1000;

  logic clk = 1'b0;
  logic rst;
  logic card_insert, password_valid, language, op_valid, another_valid, another_service;
  logic [2:0] card_number;
  logic [3:0] password_input;
  logic [1:0] operation;
  logic [BW-1:0] value;
  logic card_present, card_eject, lang_sel, op_done, error, wrong_psw, card_locked, timeout;
  logic [BW-1:0] updated_balance;

  always #5 clk = ~clk;

  atm_multi_session_ctrl #(.NUM_CARDS(NC)) dut (
    .clk(clk), .rst(rst), .card_insert(card_insert), .card_number(card_number),
    .password_valid(password_valid), .password_input(password_input), .language(language),
    .op_valid(op_valid), .operation(operation), .value(value),
    .another_valid(another_valid), .another_service(another_service),
    .card_present(card_present), .card_eject(card_eject), .lang_sel(lang_sel),
    .updated_balance(updated_balance), .op_done(op_done), .error(error),
    .wrong_psw(wrong_psw), .card_locked(card_locked), .timeout(timeout));

  typedef struct packed {
    logic present; logic eject; logic lang; logic [BW-1:0] upd;
    logic opd; logic err; logic wrong; logic lockp; logic tmo;
  } obs_t;

  obs_t q[$];
  int   qc[$];
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t observe();
    return '{card_present, card_eject, lang_sel, updated_balance,
             op_done, error, wrong_psw, card_locked, timeout};
  endfunction

  // Reference model: session state named after the behaviour, not the RTL encoding.
  int     m_st;  // 0 no session, 1 awaiting PIN, 2 menu, 3 asking for another service
  longint m_bal[NC];
  bit     m_lock[NC];
  int     m_cur, m_att, m_idle;
  longint m_wd, m_upd;
  bit     m_lang;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_bal[i] = INIT; m_lock[i] = 0; end
    m_st = 0; m_cur = 0; m_att = 0; m_idle = 0; m_wd = 0; m_upd = 0; m_lang = 0;
    q.delete(); qc.delete();
  endtask

  function automatic void model_step(input bit ins, input int cn, input bit lang,
                                     input bit pv, input int pi, input bit ov, input int op,
                                     input longint val, input bit av, input bit as);
    bit ej = 0, er = 0, od = 0, wp = 0, lk = 0, to = 0, acc = 0;
    int st0 = m_st;
    obs_t e;
    case (m_st)
      0: if (ins) begin
        acc = 1;
        if (cn >= NC)        begin er = 1; ej = 1; end
        else if (m_lock[cn]) begin lk = 1; ej = 1; end
        else begin m_cur = cn; m_lang = lang; m_att = 0; m_wd = 0; m_st = 1; end
      end
      1: if (pv) begin
        acc = 1;
        if (pi == (5 + m_cur) % 16) begin m_att = 0; m_st = 2; end
        else begin
          wp = 1; m_att++;
          if (m_att >= MAXA) begin m_lock[m_cur] = 1; lk = 1; ej = 1; m_st = 0; end
        end
      end
      2: if (ov) begin
        acc = 1;
        m_st = 3;
        case (op)
          0: begin m_upd = m_bal[m_cur]; od = 1; end
          1: if (m_bal[m_cur] + val > (longint'(1) << BW) - 1) er = 1;
             else begin m_bal[m_cur] += val; m_upd = m_bal[m_cur]; od = 1; end
          2: if (val > m_bal[m_cur] || m_wd + val > WDL) er = 1;
             else begin m_bal[m_cur] -= val; m_wd += val; m_upd = m_bal[m_cur]; od = 1; end
          default: begin ej = 1; m_st = 0; end
        endcase
      end
      default: if (av) begin
        acc = 1;
        if (as) m_st = 2;
        else begin ej = 1; m_st = 0; end
      end
    endcase
    if (st0 != 0 && !acc) begin
      m_idle++;
      if (m_idle >= T) begin to = 1; ej = 1; m_st = 0; m_idle = 0; end
    end else m_idle = 0;
    if (ej | er | od | wp | lk | to) begin
      e = '{(m_st != 0), ej, m_lang, BW'(m_upd), od, er, wp, lk, to};
      q.push_back(e);
      qc.push_back(cyc + 1);
    end
  endfunction

  task automatic drive(input bit ins, input int cn, input bit lang, input bit pv, input int pi,
                       input bit ov, input int op, input longint val, input bit av, input bit as);
    @(posedge clk); #1;
    card_insert = ins; card_number = 3'(cn); language = lang;
    password_valid = pv; password_input = 4'(pi);
    op_valid = ov; operation = 2'(op); value = BW'(val);
    another_valid = av; another_service = as;
    model_step(ins, cn, lang, pv, pi, ov, op, val, av, as);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic ins(input int c, input bit l);   drive(1, c, l, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pin(input int p);                drive(0, 0, 0, 1, p, 0, 0, 0, 0, 0); endtask
  task automatic opr(input int o, input longint v); drive(0, 0, 0, 0, 0, 1, o, v, 0, 0); endtask
  task automatic another(input bit s);            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, s); endtask

  obs_t mon_a, mon_e;
  int   mon_c;
  always @(negedge clk) begin
    if (!rst && (card_eject | op_done | error | wrong_psw | card_locked | timeout)) begin
      mon_a = observe();
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cycle=%0d actual=%h required=none", cyc, mon_a);
      end else begin
        mon_e = q.pop_front();
        mon_c = qc.pop_front();
        if (mon_a !== mon_e || cyc != mon_c) begin
          bad++;
          $display("FAIL pulse actual=%h@%0d required=%h@%0d", mon_a, cyc, mon_e, mon_c);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("FAIL %s actual=%h required=0", name, observe());
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s actual=%0d pending required=0", name, q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int pi, op;
    longint v;
    rst = 1;
    {card_insert, password_valid, language, op_valid, another_valid, another_service} = '0;
    card_number = '0; password_input = '0; operation = '0; value = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    rst = 0;

    // Basic inquiry then finish.
    ins(2, 1); pin(7); opr(0, 0); another(0); idle(2);

    // Withdrawal limit within a session, fresh limit next session.
    ins(3, 0); pin(8); opr(2, 300); another(1); opr(2, 250); another(0); idle(1);
    ins(3, 0); pin(8); opr(2, 250); another(0); idle(1);

    // Three wrong PINs lock the card; a locked card is refused at insertion.
    ins(1, 1); pin(0); pin(3); pin(15); idle(1); ins(1, 0); idle(1);

    // Invalid card index and deposit overflow boundary.
    ins(7, 0); idle(1); ins(6, 1); idle(1);
    ins(4, 1); pin(9); opr(1, (longint'(1) << BW) - INIT); another(1);
    opr(1, (longint'(1) << BW) - 1 - INIT); another(1); opr(1, 0); another(1); opr(2, 0);
    another(1); opr(3, 0); idle(1);

    // Idle timeout in MENU, then a strobe landing exactly on the expiry cycle.
    ins(0, 0); pin(5); idle(T); idle(1);
    ins(0, 0); pin(5); idle(T - 1); opr(0, 0); another(0); idle(1);
    ins(0, 1); pin(5); opr(0, 0); idle(T); idle(1);

    // Reset mid-MENU discards the committed deposit.
    ins(5, 1); pin(10); opr(1, 200); another(1); idle(2);
    check_drained("drain_before_reset");
    rst = 1;
    {card_insert, password_valid, op_valid, another_valid} = '0;
    #1 check_reset_outputs("reset_mid_session");
    @(posedge clk); #1 rst = 0;
    model_reset();
    ins(5, 0); pin(10); opr(0, 0); another(0); idle(1);

    // Randomized sessions with stray strobes that must be ignored.
    for (int s = 0; s < 60; s++) begin
      drive(1, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 5,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 20 && m_st != 0; k++) begin
        idle($urandom_range(0, 2));
        if (m_st == 1) begin
          pi = ($urandom_range(0, 3) != 0) ? (5 + m_cur) % 16 : $urandom_range(0, 15);
          drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), 0, 1, pi,
                1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), 0);
        end else if (m_st == 2) begin
          op = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
          v  = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, (1 << BW) - 1))
                                           : longint'($urandom_range(0, 320));
          drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15), 1, op, v, 1'($urandom_range(0, 1)), 0);
        end else if (m_st == 3) begin
          drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), 0, 1'($urandom_range(0, 1)),
                0, 1'($urandom_range(0, 1)), 0, 7, 1, 1'($urandom_range(0, 9) < 7));
        end
      end
      if (m_st == 2) opr(3, 0);
      else if (m_st == 3) another(0);
      idle(1);
    end

    idle(4);
    check_drained("final_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
